// File: rtl/led_ctrl_pkg.sv
// Shared types and constants for the rotating-LED sequencer.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10
  } state_e;

  localparam logic [1:0] MODE_ROTATE = 2'b00;
  localparam logic [1:0] MODE_BOUNCE = 2'b01;
  localparam logic [1:0] MODE_FILL   = 2'b10;

  function automatic logic is_active(state_e s);
    return s != ST_IDLE;
  endfunction

endpackage

// File: rtl/led_rotation_ctrl_if.sv
// Control/status bundle between the button front-end, the sequencer and the divider/LED pins.
interface led_rotation_ctrl_if #(
  parameter int unsigned N_LEDS = 8
);
  localparam int unsigned PosW = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;

  logic              tick_in;
  logic              start;
  logic              stop;
  logic              pause_req;
  logic              speed_req;
  logic [1:0]        mode;
  logic              dir;
  logic              div_pause;
  logic              div_fast;
  logic [N_LEDS-1:0] leds;
  logic [PosW-1:0]   pos;
  logic              busy;
  logic              wrap;

  modport master (
    output tick_in, start, stop, pause_req, speed_req, mode, dir,
    input  div_pause, div_fast, leds, pos, busy, wrap
  );

  modport slave (
    input  tick_in, start, stop, pause_req, speed_req, mode, dir,
    output div_pause, div_fast, leds, pos, busy, wrap
  );

endinterface

// File: rtl/tick_edge_det.sv
// Rising-edge detector for the divider tick: one step_en pulse per tick rising edge.
module tick_edge_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  output logic step_en_o
);

  logic tick_q;
  logic tick_d;

  always_comb begin
    tick_d = tick_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick_d;
    end
  end

  assign step_en_o = tick_i & ~tick_q;

endmodule

// File: rtl/led_rotation_ctrl.sv
// Rotating-LED sequencer: steps a rotate/bounce/fill pattern around an N-LED ring on each
// divider tick and drives the divider pause/fast controls.
module led_rotation_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int unsigned N_LEDS    = 8,
  parameter int unsigned START_POS = 0
) (
  input logic                clk,
  input logic                reset,
  led_rotation_ctrl_if.slave bus
);

  localparam int unsigned     PosW      = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
  localparam logic [PosW-1:0] StartPos  = PosW'(START_POS);
  localparam logic [PosW-1:0] LastPos   = PosW'(N_LEDS - 1);
  localparam logic [N_LEDS-1:0] OneLed  = N_LEDS'(1);
  localparam logic [N_LEDS-1:0] StartLeds = OneLed << START_POS;

  state_e            state_q, state_d;
  logic [PosW-1:0]   pos_q, pos_d;
  logic [N_LEDS-1:0] leds_q, leds_d;
  logic [1:0]        mode_q, mode_d;
  logic              bdir_q, bdir_d;  // bounce direction, 1 = down
  logic              fast_q, fast_d;
  logic              wrap_q, wrap_d;
  logic              busy_q, busy_d;
  logic              pause_q, pause_d;

  logic              step_en;
  logic [PosW-1:0]   pos_inc, pos_dec;
  logic [PosW-1:0]   step_pos;
  logic [N_LEDS-1:0] step_leds;
  logic              step_bdir;
  logic              step_wrap;

  tick_edge_det u_tick_edge_det (
    .clk_i     (clk),
    .rst_ni    (reset),
    .tick_i    (bus.tick_in),
    .step_en_o (step_en)
  );

  // Candidate next pattern if a step were taken this cycle.
  always_comb begin
    pos_inc   = (pos_q == LastPos) ? '0 : pos_q + PosW'(1);
    pos_dec   = (pos_q == '0) ? LastPos : pos_q - PosW'(1);
    step_pos  = pos_q;
    step_leds = leds_q;
    step_bdir = bdir_q;
    step_wrap = 1'b0;
    case (mode_q)
      MODE_BOUNCE: begin
        if (!bdir_q) begin
          if (pos_q == LastPos) begin
            step_bdir = 1'b1;
            step_pos  = pos_dec;
            step_wrap = 1'b1;
          end else begin
            step_pos = pos_inc;
          end
        end else begin
          if (pos_q == '0) begin
            step_bdir = 1'b0;
            step_pos  = pos_inc;
            step_wrap = 1'b1;
          end else begin
            step_pos = pos_dec;
          end
        end
        step_leds = OneLed << step_pos;
      end
      MODE_FILL: begin
        if (&leds_q) begin
          step_pos  = StartPos;
          step_leds = StartLeds;
          step_wrap = 1'b1;
        end else begin
          step_pos  = pos_inc;
          step_leds = leds_q | (OneLed << pos_inc);
        end
      end
      default: begin
        if (!bus.dir) begin
          step_pos  = pos_inc;
          step_wrap = (pos_q == LastPos);
        end else begin
          step_pos  = pos_dec;
          step_wrap = (pos_q == '0);
        end
        step_leds = OneLed << step_pos;
      end
    endcase
  end

  // Control events take priority over a coincident step; the step is simply dropped.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    leds_d  = leds_q;
    mode_d  = mode_q;
    bdir_d  = bdir_q;
    fast_d  = fast_q ^ bus.speed_req;
    wrap_d  = 1'b0;
    if (bus.stop) begin
      state_d = ST_IDLE;
      pos_d   = StartPos;
      leds_d  = '0;
    end else if (bus.start) begin
      state_d = ST_RUN;
      pos_d   = StartPos;
      leds_d  = StartLeds;
      mode_d  = bus.mode;
      bdir_d  = 1'b0;
    end else if (bus.pause_req && is_active(state_q)) begin
      state_d = (state_q == ST_RUN) ? ST_PAUSED : ST_RUN;
    end else if (step_en && (state_q == ST_RUN)) begin
      pos_d  = step_pos;
      leds_d = step_leds;
      bdir_d = step_bdir;
      wrap_d = step_wrap;
    end
    busy_d  = is_active(state_d);
    pause_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pos_q   <= StartPos;
      leds_q  <= '0;
      mode_q  <= MODE_ROTATE;
      bdir_q  <= 1'b0;
      fast_q  <= 1'b0;
      wrap_q  <= 1'b0;
      busy_q  <= 1'b0;
      pause_q <= 1'b1;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      leds_q  <= leds_d;
      mode_q  <= mode_d;
      bdir_q  <= bdir_d;
      fast_q  <= fast_d;
      wrap_q  <= wrap_d;
      busy_q  <= busy_d;
      pause_q <= pause_d;
    end
  end

  assign bus.leds      = leds_q;
  assign bus.pos       = pos_q;
  assign bus.busy      = busy_q;
  assign bus.div_pause = pause_q;
  assign bus.div_fast  = fast_q;
  assign bus.wrap      = wrap_q;

endmodule
